// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared types and constants for the UART receive path.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    // Parity mode encodings used by PARITY_MODE
    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_EVEN = 1;
    localparam int UART_PAR_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_param_if                                             |
// | Description : Valid/ready word interface with per-word receive status.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    // Receiver side: produces words, observes acceptance
    modport master (
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ready
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_sync                                                 |
// | Description : Two-flop synchroniser for an idle-high serial line plus a    |
// |               one-cycle falling-edge pulse on the synchronised level.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_sync (
    input  logic clk_3125,
    input  logic rst_n,
    input  logic rx,
    output logic rx_sync,
    output logic fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resynchronise the line; all flops reset high so release never looks like a start edge
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync = r_sync;
    assign fall    = r_prev & ~r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_param                                                |
// | Description : Parametrised UART receiver (data width, parity, stop bits)   |
// |               delivering words over valid/ready with parity, framing and   |
// |               overrun status. Define UART_RX_MAJORITY_EN to decide each    |
// |               data/parity/stop bit by 2-of-3 majority instead of a single  |
// |               sample.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = UART_PAR_EVEN,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk_3125,
    input  logic            rst_n,
    input  logic            rx,
    output logic            rx_busy,
    uart_rx_param_if.master rx_if
);
    localparam int              c_CW      = $clog2(CLKS_PER_BIT);
    localparam int              c_BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CW-1:0] c_HALF    = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_BW-1:0] c_DLAST   = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE = c_BW'(1);
    localparam logic            c_SLAST   = (STOP_BITS == 2);

    uart_rx_state_t       r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [c_BW-1:0]      r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic                 r_busy;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;

    logic w_line;
    logic w_fall;
    logic w_bit;
    logic w_decide;
    logic w_load;
    logic w_hs;
    logic w_ferr_new;

    uart_rx_sync u_sync (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_sync  (w_line),
        .fall     (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_CW-1:0] c_SMP_A = c_CW'(CLKS_PER_BIT - 3);
    localparam logic [c_CW-1:0] c_SMP_B = c_CW'(CLKS_PER_BIT - 2);
    logic r_smp_a;
    logic r_smp_b;

    // Capture the two samples that precede the decision point of each bit
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_a <= 1'b1;
            r_smp_b <= 1'b1;
        end else begin
            if (r_cnt == c_SMP_A) r_smp_a <= w_line;
            if (r_cnt == c_SMP_B) r_smp_b <= w_line;
        end
    end

    assign w_bit = (r_smp_a & r_smp_b) | (r_smp_a & w_line) | (r_smp_b & w_line);
`else
    assign w_bit = w_line;
`endif

    assign w_decide   = (r_cnt == c_LAST);
    assign w_load     = (r_state == STOP) && w_decide && (r_stop_idx == c_SLAST);
    assign w_ferr_new = r_ferr_acc | ~w_bit;
    assign w_hs       = r_valid & rx_if.rx_ready;

    // Frame tracker: start qualification, bit timing, data shift and error accumulation
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt <= '0;
                        if (w_line) begin
                            // Line went back high before mid-start: treat as a glitch
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= DATA;
                            r_bit_idx  <= '0;
                            r_par      <= 1'b0;
                            r_perr_acc <= 1'b0;
                            r_ferr_acc <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        r_cnt   <= '0;
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_bit;
                        if (r_bit_idx == c_DLAST) begin
                            r_state    <= (PARITY_MODE == UART_PAR_NONE) ? STOP : PARITY;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_BIT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                PARITY: begin
                    if (w_decide) begin
                        r_cnt      <= '0;
                        // Odd mode expects the inverse of the running XOR
                        r_perr_acc <= (PARITY_MODE == UART_PAR_ODD) ? (w_bit == r_par)
                                                                   : (w_bit != r_par);
                        r_state    <= STOP;
                        r_stop_idx <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        r_cnt      <= '0;
                        r_ferr_acc <= w_ferr_new;
                        if (r_stop_idx == c_SLAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: newest word wins, overrun flags a lost unaccepted word
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_shift;
            r_perr  <= r_perr_acc;
            r_ferr  <= w_ferr_new;
            r_valid <= 1'b1;
            r_ovr   <= r_valid & ~rx_if.rx_ready;
        end else if (w_hs) begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign rx_if.rx_data       = r_data;
    assign rx_if.rx_valid      = r_valid;
    assign rx_if.rx_parity_err = r_perr;
    assign rx_if.rx_frame_err  = r_ferr;
    assign rx_if.rx_overrun    = r_ovr;
    assign rx_busy             = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_param                                             |
// | Description : Self-checking bench for uart_rx_param (8E1, 14 clk/bit).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CPB = 14;
    localparam int DB  = 8;
    localparam int PM  = UART_PAR_EVEN;
    localparam int SB  = 1;
    localparam int H   = CPB / 2;
    localparam int NPB = (PM == UART_PAR_NONE) ? 0 : 1;
    localparam int NB  = 1 + DB + NPB + SB;

    logic clk_3125 = 1'b0;
    logic rst_n    = 1'b0;
    logic rx       = 1'b1;
    logic rx_busy;

    uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .PARITY_MODE  (PM),
        .STOP_BITS    (SB)
    ) dut (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_busy  (rx_busy),
        .rx_if    (rx_if)
    );

    always #5 clk_3125 = ~clk_3125;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model of the consumer-visible state
    logic          m_valid = 1'b0;
    logic          m_perr  = 1'b0;
    logic          m_ferr  = 1'b0;
    logic          m_ovr   = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_hs    = 1'b0;
    logic [DB-1:0] m_data  = '0;

    // Frame currently on the line, as scheduled by the sender
    bit            p_act   = 1'b0;
    bit            p_load  = 1'b0;
    logic          p_perr  = 1'b0;
    logic          p_ferr  = 1'b0;
    logic [DB-1:0] p_data  = '0;
    int            p_start = 0;
    int            p_end   = 0;
    bit            rnd_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Model step on every edge, then compare all outputs 1 time unit later
    always @(posedge clk_3125) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            m_ovr   = 1'b0; m_busy = 1'b0; m_data = '0;
        end else begin
            m_hs   = m_valid & rx_if.rx_ready;
            m_busy = p_act && (cyc >= p_start) && (cyc < p_end);
            if (p_act && p_load && (cyc == p_end)) begin
                m_ovr   = m_valid & ~m_hs;
                m_valid = 1'b1;
                m_data  = p_data;
                m_perr  = p_perr;
                m_ferr  = p_ferr;
            end else if (m_hs) begin
                m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end
        end
        #1;
        chk("valid",   rx_if.rx_valid,      m_valid);
        chk("busy",    rx_busy,             m_busy);
        chk("overrun", rx_if.rx_overrun,    m_ovr);
        chk("par_err", rx_if.rx_parity_err, m_perr);
        chk("frm_err", rx_if.rx_frame_err,  m_ferr);
        if (m_valid || !rst_n) chk("data", rx_if.rx_data, m_data);
    end

    function automatic logic [15:0] mk_frame(input logic [DB-1:0] d, input bit flip_par,
                                             input bit bad_stop);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[1 +: DB] = d;
        if (NPB != 0) f[1+DB] = ((PM == UART_PAR_ODD) ? ~^d : ^d) ^ flip_par;
        if (bad_stop) f[1+DB+NPB] = 1'b0;
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_3125);
    endtask

    // Schedule the expected outcome of a frame, then drive its bits
    task automatic send(input logic [15:0] bits, input int nb, input int spike, input int n_drive);
        @(negedge clk_3125);
        p_start = cyc + 3;
        p_end   = cyc + 4 + H + (nb - 1) * CPB;
        p_load  = 1'b1;
        p_data  = bits[1 +: DB];
        if (PM == UART_PAR_EVEN)     p_perr = (bits[1+DB] != ^bits[1 +: DB]);
        else if (PM == UART_PAR_ODD) p_perr = (bits[1+DB] != ~^bits[1 +: DB]);
        else                         p_perr = 1'b0;
        p_ferr  = (bits[1+DB+NPB +: SB] != {SB{1'b1}});
        p_act   = 1'b1;
        for (int i = 0; i < nb && i < n_drive; i++) begin
            for (int k = 0; k < CPB; k++) begin
                rx = (i == spike && k == H) ? ~bits[i] : bits[i];
                @(negedge clk_3125);
            end
        end
    endtask

    task automatic accept();
        @(negedge clk_3125);
        rx_if.rx_ready = 1'b1;
        @(negedge clk_3125);
        rx_if.rx_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rx_if.rx_ready = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // Clean word held with ready low
        send(mk_frame(8'hA5, 1'b0, 1'b0), NB, -1, NB);
        idle(4);
        chk("lit_a5_data",  rx_if.rx_data, 32'hA5);
        chk("lit_a5_valid", rx_if.rx_valid, 32'd1);
        chk("lit_a5_flags", {rx_if.rx_parity_err, rx_if.rx_frame_err, rx_if.rx_overrun}, 32'd0);
        chk("model_a5",     m_data, 32'hA5);
        accept();
        idle(3);

        // Wrong parity bit
        send(mk_frame(8'h3C, 1'b1, 1'b0), NB, -1, NB);
        idle(4);
        chk("lit_3c_data", rx_if.rx_data, 32'h3C);
        chk("lit_3c_perr", rx_if.rx_parity_err, 32'd1);
        accept();
        idle(3);

        // Bad stop bit, then a break after a short idle
        send(mk_frame(8'h55, 1'b0, 1'b1), NB, -1, NB);
        chk("lit_55_data", rx_if.rx_data, 32'h55);
        chk("lit_55_ferr", rx_if.rx_frame_err, 32'd1);
        accept();
        rx = 1'b1;
        idle(2 * CPB);
        send(16'h0000, NB, -1, NB);
        chk("lit_brk_data", rx_if.rx_data, 32'h00);
        chk("lit_brk_ferr", rx_if.rx_frame_err, 32'd1);
        accept();
        idle(2 * NB * CPB);
        chk("lit_brk_none", rx_if.rx_valid, 32'd0);
        rx = 1'b1;
        idle(3 * CPB);

        // Overrun: second word lands while the first is unaccepted
        send(mk_frame(8'h11, 1'b0, 1'b0), NB, -1, NB);
        send(mk_frame(8'h22, 1'b0, 1'b0), NB, -1, NB);
        idle(2);
        chk("lit_ovr_data", rx_if.rx_data, 32'h22);
        chk("lit_ovr_flag", rx_if.rx_overrun, 32'd1);
        accept();
        chk("lit_ovr_clr", {rx_if.rx_valid, rx_if.rx_overrun}, 32'd0);
        idle(3);

        // Short low glitch on an idle line
        @(negedge clk_3125);
        p_start = cyc + 3;
        p_end   = cyc + 4 + H;
        p_load  = 1'b0;
        p_act   = 1'b1;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(2 * CPB);
        chk("lit_glitch_novalid", rx_if.rx_valid, 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle spike at a data-bit centre is voted out
        send(mk_frame(8'h5A, 1'b0, 1'b0), NB, 3, NB);
        idle(2);
        chk("lit_spike_data", rx_if.rx_data, 32'h5A);
        accept();
        idle(3);
`endif

        // Reset in the middle of the data bits, then a clean word
        send(mk_frame(8'h99, 1'b0, 1'b0), NB, -1, 5);
        rst_n = 1'b0;
        p_act = 1'b0;
        rx    = 1'b1;
        idle(6);
        chk("lit_rst_outs", {rx_if.rx_valid, rx_busy, rx_if.rx_parity_err,
                             rx_if.rx_frame_err, rx_if.rx_overrun}, 32'd0);
        chk("lit_rst_data", rx_if.rx_data, 32'd0);
        rst_n = 1'b1;
        idle(10);
        send(mk_frame(8'h7E, 1'b0, 1'b0), NB, -1, NB);
        idle(2);
        chk("lit_7e_data", rx_if.rx_data, 32'h7E);
        accept();
        idle(3);

        // Randomised traffic with random consumer back-pressure
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    logic [DB-1:0] d;
                    d = DB'($urandom);
                    send(mk_frame(d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0)),
                         NB, -1, NB);
                    @(negedge clk_3125);
                    rx = 1'b1;
                    idle(1 + $urandom_range(0, 30));
                end
                idle(2 * CPB);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk_3125);
                    rx_if.rx_ready = ($urandom_range(0, 3) == 0);
                end
            end
        join
        rx_if.rx_ready = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
